tick_debouncer: RTL and testbench

- Consumes the periodic one-cycle `tick` strobe from the system clock divider.
- Produces a debounced, glitch-free level from a raw mechanical switch or button.
- Also produces one-cycle rise and fall strobes.
- Sits between board push-buttons/switches and the counter control logic, so each button press yields exactly one count event.

---
 rtl/tick_debouncer.sv | 114 +++++++++++
 tb/tb_tick_debouncer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_debouncer.sv
// Tick-paced switch debouncer: two-flop synchronizer, four-state qualifier,
// registered level plus one-cycle rise/fall strobes.
module tick_debouncer #(
    parameter int STABLE_TICKS = 3
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_t;

    localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);

    logic       s1_q;
    logic       sw_s_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            sw_s_q <= 1'b0;
        end else begin
            s1_q   <= sw;
            sw_s_q <= s1_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ZERO;
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A reversal of sw_s is checked before tick, so it wins a tie.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ZERO: begin
                if (sw_s_q) begin
                    state_d = WAIT1;
                    cnt_d   = 4'd0;
                end
            end
            WAIT1: begin
                if (!sw_s_q) begin
                    state_d = ZERO;
                    cnt_d   = 4'd0;
                end else if (tick && cnt_q == LAST) begin
                    state_d = ONE;
                    cnt_d   = 4'd0;
                end else if (tick) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ONE: begin
                if (!sw_s_q) begin
                    state_d = WAIT0;
                    cnt_d   = 4'd0;
                end
            end
            WAIT0: begin
                if (sw_s_q) begin
                    state_d = ONE;
                    cnt_d   = 4'd0;
                end else if (tick && cnt_q == LAST) begin
                    state_d = ZERO;
                    cnt_d   = 4'd0;
                end else if (tick) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        level_d = (state_d == ONE) || (state_d == WAIT0);
        rise_d  = (state_q == WAIT1) && (state_d == ONE);
        fall_d  = (state_q == WAIT0) && (state_d == ZERO);
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;

endmodule

// File: tb/tb_tick_debouncer.sv
// Directed bench for tick_debouncer: STABLE_TICKS=3 with sparse ticks,
// and STABLE_TICKS=1 with tick tied high.
module tb_tick_debouncer;

    logic clk_in;
    logic reset;
    logic tick3, sw3, lvl3, rise3, fall3;
    logic tick1, sw1, lvl1, rise1, fall1;

    int nchecks;
    int nfail;
    int overlap;

    tick_debouncer #(.STABLE_TICKS(3)) u3 (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick    (tick3),
        .sw      (sw3),
        .db_level(lvl3),
        .db_rise (rise3),
        .db_fall (fall3)
    );

    tick_debouncer #(.STABLE_TICKS(1)) u1 (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick    (tick1),
        .sw      (sw1),
        .db_level(lvl1),
        .db_rise (rise1),
        .db_fall (fall1)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        if (rise3 && fall3) overlap++;
        if (rise1 && fall1) overlap++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        nchecks++;
        if ({lvl3, rise3, fall3} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_async3: got %b want 000", {lvl3, rise3, fall3});
        end
        nchecks++;
        if ({lvl1, rise1, fall1} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_async1: got %b want 000", {lvl1, rise1, fall1});
        end
        step();
        step();
        nchecks++;
        if ({lvl3, rise3, fall3} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_hold3: got %b want 000", {lvl3, rise3, fall3});
        end
        reset = 1'b0;
        sw3   = 1'b0;
        tick3 = 1'b0;
        for (int n = 0; n < 4; n++) step();
    endtask

    task automatic test_reset_mid();
        int rise_at;
        int rises;
        rise_at = 0;
        rises   = 0;
        sw3 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick3 = (n % 4 == 0);
            step();
        end
        tick3 = 1'b0;
        reset = 1'b1;
        #2;
        nchecks++;
        if ({lvl3, rise3, fall3} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_mid: got %b want 000", {lvl3, rise3, fall3});
        end
        step();
        step();
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick3 = (n % 4 == 0);
            step();
            if (rise3) begin
                rises++;
                if (rise_at == 0) rise_at = n;
            end
        end
        tick3 = 1'b0;
        nchecks++;
        if (rise_at !== 12) begin
            nfail++;
            $display("FAIL reset_mid_rise_at: got %0d want 12", rise_at);
        end
        nchecks++;
        if (rises !== 1) begin
            nfail++;
            $display("FAIL reset_mid_rises: got %0d want 1", rises);
        end
    endtask

    task automatic test_clean_rise();
        int rise_at;
        int rises;
        int falls;
        rise_at = 0;
        rises   = 0;
        falls   = 0;
        sw3 = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick3 = (n % 4 == 0);
            step();
            if (n == 11) begin
                nchecks++;
                if (lvl3 !== 1'b0) begin
                    nfail++;
                    $display("FAIL rise_early_level: got %b want 0", lvl3);
                end
            end
            if (rise3) begin
                rises++;
                if (rise_at == 0) rise_at = n;
            end
            if (fall3) falls++;
        end
        tick3 = 1'b0;
        nchecks++;
        if (rise_at !== 12) begin
            nfail++;
            $display("FAIL rise_at: got %0d want 12", rise_at);
        end
        nchecks++;
        if (rises !== 1 || falls !== 0) begin
            nfail++;
            $display("FAIL rise_count: got r=%0d f=%0d want r=1 f=0", rises, falls);
        end
        nchecks++;
        if (lvl3 !== 1'b1) begin
            nfail++;
            $display("FAIL rise_level: got %b want 1", lvl3);
        end
    endtask

    task automatic test_clean_fall();
        int fall_at;
        int rises;
        int falls;
        fall_at = 0;
        rises   = 0;
        falls   = 0;
        sw3 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick3 = (n % 4 == 0);
            step();
            if (fall3) begin
                falls++;
                if (fall_at == 0) fall_at = n;
            end
            if (rise3) rises++;
        end
        tick3 = 1'b0;
        nchecks++;
        if (fall_at !== 12) begin
            nfail++;
            $display("FAIL fall_at: got %0d want 12", fall_at);
        end
        nchecks++;
        if (falls !== 1 || rises !== 0) begin
            nfail++;
            $display("FAIL fall_count: got f=%0d r=%0d want f=1 r=0", falls, rises);
        end
        nchecks++;
        if (lvl3 !== 1'b0) begin
            nfail++;
            $display("FAIL fall_level: got %b want 0", lvl3);
        end
    endtask

    task automatic test_simultaneous();
        int rise_at;
        int rises;
        rise_at = 0;
        rises   = 0;
        for (int n = 1; n <= 30; n++) begin
            sw3   = (n == 10) ? 1'b0 : 1'b1;
            tick3 = (n % 4 == 0);
            step();
            if (n == 12) begin
                nchecks++;
                if ({lvl3, rise3} !== 2'b00) begin
                    nfail++;
                    $display("FAIL simul_edge: got lvl/rise %b want 00", {lvl3, rise3});
                end
            end
            if (rise3) begin
                rises++;
                if (rise_at == 0) rise_at = n;
            end
        end
        tick3 = 1'b0;
        nchecks++;
        if (rise_at !== 24) begin
            nfail++;
            $display("FAIL simul_requal_at: got %0d want 24", rise_at);
        end
        nchecks++;
        if (rises !== 1) begin
            nfail++;
            $display("FAIL simul_rises: got %0d want 1", rises);
        end
    endtask

    task automatic test_bounce();
        int rise_at;
        int rises;
        int bounce_rises;
        int hi_cycles;
        rise_at      = 0;
        rises        = 0;
        bounce_rises = 0;
        hi_cycles    = 0;
        for (int n = 1; n <= 40; n++) begin
            sw3   = (((n - 1) / 5) % 2 == 0);
            tick3 = (n % 4 == 0);
            step();
            if (rise3) bounce_rises++;
            if (lvl3) hi_cycles++;
        end
        for (int n = 41; n <= 60; n++) begin
            sw3   = 1'b1;
            tick3 = (n % 4 == 0);
            step();
            if (rise3) begin
                rises++;
                if (rise_at == 0) rise_at = n;
            end
        end
        tick3 = 1'b0;
        nchecks++;
        if (bounce_rises !== 0 || hi_cycles !== 0) begin
            nfail++;
            $display("FAIL bounce_reject: got rises=%0d hi=%0d want 0 0", bounce_rises, hi_cycles);
        end
        nchecks++;
        if (rise_at !== 52) begin
            nfail++;
            $display("FAIL bounce_settle_at: got %0d want 52", rise_at);
        end
        nchecks++;
        if (rises !== 1 || lvl3 !== 1'b1) begin
            nfail++;
            $display("FAIL bounce_settle: got rises=%0d lvl=%b want 1 1", rises, lvl3);
        end
    endtask

    task automatic test_continuous_tick();
        int at;
        int r;
        int f;
        tick1 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            sw1 = ~sw1;
            at  = 0;
            r   = 0;
            f   = 0;
            for (int n = 1; n <= 20; n++) begin
                step();
                if ((rise1 || fall1) && at == 0) at = n;
                if (rise1) r++;
                if (fall1) f++;
            end
            nchecks++;
            if (at !== 4) begin
                nfail++;
                $display("FAIL cont_latency e%0d: got %0d want 4", e, at);
            end
            nchecks++;
            if (r !== (sw1 ? 1 : 0) || f !== (sw1 ? 0 : 1) || lvl1 !== sw1) begin
                nfail++;
                $display("FAIL cont_strobes e%0d: got r=%0d f=%0d lvl=%b want sw=%b",
                         e, r, f, lvl1, sw1);
            end
        end
        tick1 = 1'b0;
    endtask

    initial begin
        nchecks = 0;
        nfail   = 0;
        overlap = 0;
        reset   = 1'b1;
        tick3   = 1'b0;
        sw3     = 1'b0;
        tick1   = 1'b0;
        sw1     = 1'b0;
        test_reset();
        test_reset_mid();
        test_clean_fall();
        test_clean_rise();
        test_clean_fall();
        test_simultaneous();
        test_clean_fall();
        test_bounce();
        test_continuous_tick();
        test_reset();
        nchecks++;
        if (overlap !== 0) begin
            nfail++;
            $display("FAIL strobe_overlap: got %0d cycles want 0", overlap);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
